serial_port: RTL and testbench
==============================

Name: serial_port

Overview:
- MMIO serial link controller on the shared `addr_ext`/`data_ext` bus, alongside the timers block.
- Implements the SB data register (`MMIO_SB`, 0xFF01) and the SC control register (`MMIO_SC`, 0xFF02).
- Shifts 8 bits MSB-first, using either an internally generated bit clock or an external one.
- Pulses `serial_interrupt` on completion; this feeds `IF_in[I_SERIAL]` and `IF_load` upstream of the cpu.

Parameters:
- CLKS_PER_BIT, 512, system clocks per serial bit in internal-clock mode. Must be even and ≥4.
- SYNC_STAGES, 2, synchronizer flops on `serial_clk_in`. Must be ≥2.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- addr_ext  input  16  shared address bus.
- data_ext  inout  8  shared data bus. Driven only on a read hit, high-Z otherwise.
- mem_re  input  1  bus read strobe.
- mem_we  input  1  bus write strobe.
- serial_in  input  1  incoming serial data.
- serial_clk_in  input  1  external serial clock, asynchronous.
- serial_out  output  1  outgoing serial data.
- serial_clk_out  output  1  generated serial clock in internal mode.
- serial_interrupt  output  1  one-cycle transfer-complete pulse.
- busy  output  1  equals SC[7].

Behaviour:
- Registers: SB[7:0]; SC has only bits 7 (start/busy) and 0 (clock select, 1 = internal) implemented.
- Reads (combinational):
  - When `mem_re` is high and `addr_ext` == `MMIO_SB`, drive `data_ext` = SB.
  - When `mem_re` is high and `addr_ext` == `MMIO_SC`, drive `data_ext` = {SC[7], 6'b111111, SC[0]}.
  - Otherwise `data_ext` is Z.
- Writes: sampled at posedge when `mem_we` is high and the address matches.
  - SB writes are ignored while busy.
  - An SC write updates bits 7 and 0.
- Reset values: SB = 0x00, SC = 0 (so SC reads 0x7E), `serial_interrupt` = 0, `serial_clk_out` = 1, `serial_out` = 1, bit_cnt = 0, timer = 0, synchronizer flops = 0.
- States: IDLE, SHIFT_INT, SHIFT_EXT.
  - IDLE → SHIFT_INT on an SC write with bit7 = 1 and bit0 = 1.
  - IDLE → SHIFT_EXT on an SC write with bit7 = 1 and bit0 = 0.
  - bit_cnt and timer are cleared on entry to either shift state.
- SHIFT_INT:
  - timer counts 0..CLKS_PER_BIT-1 and wraps.
  - `serial_clk_out` = 0 while timer < CLKS_PER_BIT/2, and 1 otherwise.
  - `serial_in` is captured into a sample flop at timer == CLKS_PER_BIT/2 (rising edge of `serial_clk_out`).
  - At timer == CLKS_PER_BIT-1: SB <= {SB[6:0], sample} and bit_cnt++.
- SHIFT_EXT:
  - `serial_clk_in` passes through SYNC_STAGES flops; a rising edge is detected on the synchronized value.
  - On each detected edge: SB <= {SB[6:0], serial_in} and bit_cnt++.
  - `serial_clk_out` is held at 1.
- `serial_out` = SB[7] in both shift states, and 1 in IDLE.
- Completion: on the shift that brings bit_cnt to 8:
  - SC[7] <= 0;
  - the state returns to IDLE;
  - `serial_interrupt` = 1 for exactly the next cycle.
- Internal-mode latency: SC write at edge N → `serial_interrupt` high during the cycle following edge N + 8·CLKS_PER_BIT.
- Abort: an SC write with bit7 = 0 while busy returns to IDLE immediately. No interrupt; SB keeps its partially shifted value.
- Restart: an SC write with bit7 = 1 while busy restarts from bit 0 with the current SB and the new clock select.
- Simultaneous SC write and final shift:
  - the final shift commits to SB and the interrupt still pulses;
  - SC then takes the written value; if that value has bit7 = 1, a new transfer starts.
- Simultaneous SB write and any shift while busy: the SB write is dropped.
- Reset mid-transfer: all state returns to reset values next cycle, with no interrupt.
- External edges while IDLE are ignored.

Test Plan:
- After reset: read SB → 0x00; read SC → 0x7E; `serial_clk_out` = 1, `serial_out` = 1, `serial_interrupt` = 0.
- Internal loopback (`serial_out` tied to `serial_in`), CLKS_PER_BIT = 8: write SB = 0xA5, SC = 0x81.
  - `serial_clk_out` toggles 8 periods, each 4 cycles low then 4 cycles high.
  - `serial_interrupt` is high for one cycle, 64 cycles after the write.
  - SB reads 0xA5 and SC reads 0x7F.
- External mode, `serial_in` = 1 constantly: write SB = 0x3C, SC = 0x80, then apply 8 slow rising edges on `serial_clk_in`.
  - Output bits observed: 0,0,1,1,1,1,0,0.
  - SB = 0xFF afterwards, one interrupt pulse, SC reads 0x7E.
- Abort: start an internal transfer, write SC = 0x01 after 3 bits.
  - `busy` drops next cycle, no interrupt within 16·CLKS_PER_BIT cycles, `serial_clk_out` = 1.
- SB write while busy is ignored: start with SB = 0x0F, write SB = 0xFF mid-transfer, loopback.
  - Final SB = 0x0F.
- Reset asserted mid-transfer for one cycle: `busy` = 0, SB = 0x00, no interrupt.
  - `data_ext` is Z whenever no read hit occurs (e.g. a read of 0xFF03).

Source files
------------

// File: rtl/serial_port.sv
// serial_port: MMIO serial link controller (SB data / SC control registers).
// Shifts 8 bits MSB-first using an internal bit clock or an external,
// synchronized serial clock, and pulses serial_interrupt on completion.
module serial_port #(
  parameter int CLKS_PER_BIT = 512,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        serial_in,
  input  logic        serial_clk_in,
  output logic        serial_out,
  output logic        serial_clk_out,
  output logic        serial_interrupt,
  output logic        busy
);

  localparam logic [15:0] MMIO_SB = 16'hFF01;
  localparam logic [15:0] MMIO_SC = 16'hFF02;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_INT,
    SHIFT_EXT
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [7:0]             r_sb;
  logic                   r_scStart;
  logic                   r_scIntClk;
  logic [3:0]             r_bitCnt;
  logic [TW-1:0]          r_timer;
  logic                   r_sample;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_syncPrev;
  logic                   r_interrupt;

  logic       w_sbWrite;
  logic       w_scWrite;
  logic       w_start;
  logic       w_edge;
  logic       w_shift;
  logic       w_shiftBit;
  logic       w_done;
  logic       w_readHit;
  logic [7:0] w_readData;

  assign w_sbWrite = mem_we && (addr_ext == MMIO_SB);
  assign w_scWrite = mem_we && (addr_ext == MMIO_SC);
  // Any SC write with the start bit set (re)starts a transfer from bit 0.
  assign w_start   = w_scWrite && data_ext[7];

  assign w_edge     = r_sync[SYNC_STAGES-1] && !r_syncPrev;
  assign w_shift    = ((r_state == SHIFT_INT) && (r_timer == TIMER_LAST)) ||
                      ((r_state == SHIFT_EXT) && w_edge);
  assign w_shiftBit = (r_state == SHIFT_INT) ? r_sample : serial_in;
  assign w_done     = w_shift && (r_bitCnt == 4'd7);

  // Reads are combinational; the bus is released unless a register is hit.
  assign w_readHit  = mem_re && ((addr_ext == MMIO_SB) || (addr_ext == MMIO_SC));
  assign w_readData = (addr_ext == MMIO_SB) ? r_sb : {r_scStart, 6'b111111, r_scIntClk};
  assign data_ext   = w_readHit ? w_readData : 8'bz;

  assign busy             = r_scStart;
  assign serial_interrupt = r_interrupt;

  // State register for the transfer FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and serial pin outputs; an SC write overrides completion so a
  // start bit written on the final shift launches the next transfer.
  always_comb begin
    w_nextState    = r_state;
    serial_out     = 1'b1;
    serial_clk_out = 1'b1;
    case (r_state)
      SHIFT_INT: begin
        serial_out     = r_sb[7];
        serial_clk_out = (r_timer >= TIMER_HALF);
        if (w_done) w_nextState = IDLE;
      end
      SHIFT_EXT: begin
        serial_out = r_sb[7];
        if (w_done) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_scWrite) begin
      if (!data_ext[7])     w_nextState = IDLE;
      else if (data_ext[0]) w_nextState = SHIFT_INT;
      else                  w_nextState = SHIFT_EXT;
    end
  end

  // Registers, bit timer, synchronizer and shift datapath; a shift always
  // wins over an SB write, and SB writes are dropped while busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sb        <= 8'h00;
      r_scStart   <= 1'b0;
      r_scIntClk  <= 1'b0;
      r_bitCnt    <= 4'd0;
      r_timer     <= '0;
      r_sample    <= 1'b0;
      r_sync      <= '0;
      r_syncPrev  <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], serial_clk_in};
      r_syncPrev  <= r_sync[SYNC_STAGES-1];
      r_interrupt <= w_done;

      if (w_shift) begin
        r_sb <= {r_sb[6:0], w_shiftBit};
      end else if (w_sbWrite && !r_scStart) begin
        r_sb <= data_ext;
      end

      if (w_scWrite) begin
        r_scStart  <= data_ext[7];
        r_scIntClk <= data_ext[0];
      end else if (w_done) begin
        r_scStart <= 1'b0;
      end

      if (w_start) begin
        r_bitCnt <= 4'd0;
        r_timer  <= '0;
      end else begin
        if (w_shift) r_bitCnt <= r_bitCnt + 4'd1;
        if (r_state == SHIFT_INT) begin
          r_timer <= (r_timer == TIMER_LAST) ? '0 : r_timer + TW'(1);
        end else begin
          r_timer <= '0;
        end
      end

      if ((r_state == SHIFT_INT) && (r_timer == TIMER_HALF)) begin
        r_sample <= serial_in;
      end
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: directed bench for serial_port with a per-cycle reference
// model of internal-clock transfers and literal expectations for each scenario.
module tb_serial_port;

  localparam int CPB = 8;
  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_ext = 16'h0000;
  wire  [7:0]  data_ext;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic        serial_in;
  logic        serial_clk_in = 1'b0;
  logic        serial_out;
  logic        serial_clk_out;
  logic        serial_interrupt;
  logic        busy;

  logic       loopBack = 1'b0;
  logic       serialInDrv = 1'b1;
  logic       tbDrive = 1'b0;
  logic [7:0] tbData = 8'h00;

  int errorCount = 0;
  int checkCount = 0;
  int intCount = 0;

  // Model: mode 0 = idle, 1 = internal transfer in flight, 2 = external transfer.
  int         mode = 0;
  int         mK = 0;
  logic [7:0] mSb0 = 8'h00;
  bit         checkEn = 1'b0;
  logic       eBusy, eClk, eOut, eInt;

  assign serial_in = loopBack ? serial_out : serialInDrv;
  assign data_ext  = tbDrive ? tbData : 8'bz;

  serial_port #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock(clock),
    .reset(reset),
    .addr_ext(addr_ext),
    .data_ext(data_ext),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .serial_in(serial_in),
    .serial_clk_in(serial_clk_in),
    .serial_out(serial_out),
    .serial_clk_out(serial_clk_out),
    .serial_interrupt(serial_interrupt),
    .busy(busy)
  );

  // 10-unit system clock.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
    end
  endtask

  // One bus write, sampled at the next rising edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] value);
    @(negedge clock);
    addr_ext = addr;
    tbData   = value;
    tbDrive  = 1'b1;
    mem_we   = 1'b1;
    @(posedge clock);
    #1;
    mem_we  = 1'b0;
    tbDrive = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] addr, output logic [7:0] value);
    @(negedge clock);
    addr_ext = addr;
    mem_re   = 1'b1;
    #1;
    value  = data_ext;
    mem_re = 1'b0;
  endtask

  // Load SB then launch an internal-clock transfer; model starts counting at k=0.
  task automatic startInternal(input logic [7:0] sbValue);
    applyStimulus(ADDR_SB, sbValue);
    applyStimulus(ADDR_SC, 8'h81);
    mSb0 = sbValue;
    mK   = 0;
    mode = 1;
  endtask

  task automatic waitInterrupt(input int limit, output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (!found && cycles < limit) begin
      @(negedge clock);
      if (serial_interrupt) found = 1'b1;
      else cycles++;
    end
  endtask

  // Per-cycle compare of the serial pins against the model, away from posedge.
  always @(negedge clock) begin
    if (serial_interrupt) intCount++;
    if (checkEn) begin
      if (mode == 2) begin
        checkOutput("extClkOut", {7'b0, serial_clk_out}, 8'h01);
      end else begin
        if (mode == 1 && mK < 8 * CPB) begin
          eBusy = 1'b1;
          eClk  = ((mK % CPB) >= CPB / 2);
          eOut  = mSb0[7 - mK / CPB];
          eInt  = 1'b0;
        end else begin
          eBusy = 1'b0;
          eClk  = 1'b1;
          eOut  = 1'b1;
          eInt  = (mode == 1);
        end
        checkOutput("cycBusy", {7'b0, busy}, {7'b0, eBusy});
        checkOutput("cycClkOut", {7'b0, serial_clk_out}, {7'b0, eClk});
        checkOutput("cycSerOut", {7'b0, serial_out}, {7'b0, eOut});
        checkOutput("cycIrq", {7'b0, serial_interrupt}, {7'b0, eInt});
        if (mode == 1) begin
          if (mK >= 8 * CPB) mode = 0;
          else mK++;
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    logic [7:0] rd;
    logic [7:0] expBitsExt;
    int         cycles;
    bit         found;
    int         intBefore;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset   = 1'b0;
    checkEn = 1'b1;

    // Reset state.
    readReg(ADDR_SB, rd);
    checkOutput("resetSb", rd, 8'h00);
    readReg(ADDR_SC, rd);
    checkOutput("resetSc", rd, 8'h7E);
    checkOutput("resetClkOut", {7'b0, serial_clk_out}, 8'h01);
    checkOutput("resetSerOut", {7'b0, serial_out}, 8'h01);
    checkOutput("resetIrq", {7'b0, serial_interrupt}, 8'h00);

    // Internal loopback of 0xA5: interrupt 64 cycles after the SC write.
    loopBack = 1'b1;
    startInternal(8'hA5);
    waitInterrupt(200, cycles, found);
    checkOutput("loopIrqFound", {7'b0, found}, 8'h01);
    checkOutput("loopIrqLatency", 8'(cycles), 8'd64);
    readReg(ADDR_SB, rd);
    checkOutput("loopSb", rd, 8'hA5);
    readReg(ADDR_SC, rd);
    checkOutput("loopSc", rd, 8'h7F);

    // External clock, serial_in held high.
    loopBack    = 1'b0;
    serialInDrv = 1'b1;
    applyStimulus(ADDR_SB, 8'h3C);
    applyStimulus(ADDR_SC, 8'h80);
    mode       = 2;
    intBefore  = intCount;
    expBitsExt = 8'b0011_1100;
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      checkOutput($sformatf("extBit%0d", b), {7'b0, serial_out}, {7'b0, expBitsExt[7 - b]});
      if (b == 3) checkOutput("extBusy", {7'b0, busy}, 8'h01);
      serial_clk_in = 1'b1;
      repeat (6) @(negedge clock);
      serial_clk_in = 1'b0;
      repeat (6) @(negedge clock);
    end
    mode = 0;
    checkOutput("extIrqCount", 8'(intCount - intBefore), 8'd1);
    readReg(ADDR_SB, rd);
    checkOutput("extSb", rd, 8'hFF);
    readReg(ADDR_SC, rd);
    checkOutput("extSc", rd, 8'h7E);

    // External edges while idle change nothing.
    serialInDrv = 1'b0;
    intBefore   = intCount;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      serial_clk_in = 1'b1;
      repeat (4) @(negedge clock);
      serial_clk_in = 1'b0;
      repeat (4) @(negedge clock);
    end
    readReg(ADDR_SB, rd);
    checkOutput("idleEdgeSb", rd, 8'hFF);
    checkOutput("idleEdgeIrq", 8'(intCount - intBefore), 8'd0);

    // Abort after three bits: 0xC3 rotated left by 3 is 0x1E.
    loopBack = 1'b1;
    startInternal(8'hC3);
    repeat (26) @(negedge clock);
    applyStimulus(ADDR_SC, 8'h01);
    mode      = 0;
    intBefore = intCount;
    @(negedge clock);
    checkOutput("abortBusy", {7'b0, busy}, 8'h00);
    repeat (16 * CPB) @(negedge clock);
    checkOutput("abortIrq", 8'(intCount - intBefore), 8'd0);
    checkOutput("abortClkOut", {7'b0, serial_clk_out}, 8'h01);
    readReg(ADDR_SB, rd);
    checkOutput("abortSb", rd, 8'h1E);
    readReg(ADDR_SC, rd);
    checkOutput("abortSc", rd, 8'h7F);

    // SB write while busy is dropped.
    startInternal(8'h0F);
    repeat (20) @(negedge clock);
    applyStimulus(ADDR_SB, 8'hFF);
    waitInterrupt(200, cycles, found);
    checkOutput("busyWrIrqFound", {7'b0, found}, 8'h01);
    readReg(ADDR_SB, rd);
    checkOutput("busyWrSb", rd, 8'h0F);

    // Bus released when no read hits; the bench drives 0x00 underneath.
    @(negedge clock);
    tbData   = 8'h00;
    tbDrive  = 1'b1;
    addr_ext = 16'hFF03;
    mem_re   = 1'b1;
    #1;
    checkOutput("noHitFF03", data_ext, 8'h00);
    mem_re   = 1'b0;
    addr_ext = ADDR_SC;
    #1;
    checkOutput("noReadSc", data_ext, 8'h00);
    tbDrive = 1'b0;

    // Reset mid-transfer.
    startInternal(8'h5A);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    mode      = 0;
    intBefore = intCount;
    @(negedge clock);
    checkOutput("rstBusy", {7'b0, busy}, 8'h00);
    readReg(ADDR_SB, rd);
    checkOutput("rstSb", rd, 8'h00);
    readReg(ADDR_SC, rd);
    checkOutput("rstSc", rd, 8'h7E);
    repeat (16 * CPB) @(negedge clock);
    checkOutput("rstIrq", 8'(intCount - intBefore), 8'd0);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
